// File: rtl/apb_decode_mux.sv
// apb_decode_mux: APB address-rule demux with unmapped-access error responder and ACCESS-phase timeout watchdog.
module apb_decode_mux #(
  parameter int NumSlaves = 4,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter logic [NumSlaves-1:0][AddrWidth-1:0] SlvBase = '0,
  parameter logic [NumSlaves-1:0][AddrWidth-1:0] SlvLast = '0,
  parameter int TimeoutCycles = 255
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                s_psel_i,
  input  logic                                s_penable_i,
  input  logic                                s_pwrite_i,
  input  logic [AddrWidth-1:0]                s_paddr_i,
  input  logic [DataWidth-1:0]                s_pwdata_i,
  output logic [DataWidth-1:0]                s_prdata_o,
  output logic                                s_pready_o,
  output logic                                s_pslverr_o,
  output logic [NumSlaves-1:0]                m_psel_o,
  output logic                                m_penable_o,
  output logic                                m_pwrite_o,
  output logic [AddrWidth-1:0]                m_paddr_o,
  output logic [DataWidth-1:0]                m_pwdata_o,
  input  logic [NumSlaves-1:0][DataWidth-1:0] m_prdata_i,
  input  logic [NumSlaves-1:0]                m_pready_i,
  input  logic [NumSlaves-1:0]                m_pslverr_i,
  input  logic                                err_clr_i,
  output logic                                err_valid_o,
  output logic                                err_timeout_o,
  output logic [AddrWidth-1:0]                err_addr_o,
  output logic                                err_irq_o
);
  localparam int SW = NumSlaves > 1 ? $clog2(NumSlaves) : 1;
  localparam int CW = TimeoutCycles > 0 ? $clog2(TimeoutCycles + 1) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, ERR_RESP} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] sel_q, hit_idx;
  logic [CW-1:0] cnt_q;
  logic hit, setup, sel_ready, timeout, err_resp, fwd;
  // Scan downwards so the lowest matching rule index wins on overlap.
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = NumSlaves - 1; i >= 0; i--)
      if (s_paddr_i >= SlvBase[i] && s_paddr_i < SlvLast[i]) begin
        hit = 1'b1;
        hit_idx = SW'(i);
      end
  end
  assign setup     = s_psel_i & ~s_penable_i;
  assign sel_ready = m_pready_i[sel_q];
  assign timeout   = TimeoutCycles != 0 && state_q == ACCESS && s_psel_i && s_penable_i
                     && cnt_q == CW'(TimeoutCycles);
  assign err_resp  = state_q == ERR_RESP && s_psel_i && s_penable_i;
  assign fwd       = state_q == ACCESS && !timeout;
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = !setup ? IDLE : hit ? ACCESS : ERR_RESP;
    else if (!s_psel_i || timeout || err_resp || (state_q == ACCESS && s_penable_i && sel_ready))
      state_d = IDLE;
  end
  always_comb begin
    m_psel_o = '0;
    if (state_q == IDLE && setup && hit) m_psel_o[hit_idx] = 1'b1;
    else if (state_q == ACCESS && s_psel_i && !timeout) m_psel_o[sel_q] = 1'b1;
    m_penable_o = state_q == ACCESS && s_psel_i && s_penable_i && !timeout;
    s_pready_o  = fwd ? sel_ready : (timeout | err_resp);
    s_pslverr_o = fwd ? m_pslverr_i[sel_q] : (timeout | err_resp);
    s_prdata_o  = fwd ? m_prdata_i[sel_q] : '0;
    m_pwrite_o  = s_pwrite_i;
    m_paddr_o   = s_paddr_i;
    m_pwdata_o  = s_pwdata_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q         <= '0;
      cnt_q         <= '0;
      err_valid_o   <= 1'b0;
      err_timeout_o <= 1'b0;
      err_addr_o    <= '0;
      err_irq_o     <= 1'b0;
    end else begin
      if (state_q == IDLE && setup && hit) sel_q <= hit_idx;
      cnt_q <= (state_q == ACCESS && state_d == ACCESS) ? cnt_q + CW'(s_penable_i & ~sel_ready) : '0;
      err_irq_o <= timeout | err_resp;
      if (timeout | err_resp) begin
        err_valid_o   <= 1'b1;
        err_timeout_o <= timeout;
        err_addr_o    <= s_paddr_i;
      end else if (err_clr_i) err_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_apb_decode_mux.sv
// tb_apb_decode_mux: randomized APB transfers against a rule-level model of decode, timeout and error record.
module tb_apb_decode_mux;
  localparam int N = 4, AW = 32, DW = 32, T = 8;
  localparam logic [N-1:0][AW-1:0] BASE = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
  localparam logic [N-1:0][AW-1:0] LAST = {32'h5000, 32'h4000, 32'h3000, 32'h2000};
  logic clk = 0, rst = 1;
  logic s_psel = 0, s_penable = 0, s_pwrite = 0, err_clr = 0;
  logic [AW-1:0] s_paddr = '0, m_paddr, err_addr;
  logic [DW-1:0] s_pwdata = '0, s_prdata, m_pwdata;
  logic s_pready, s_pslverr, m_penable, m_pwrite, err_valid, err_timeout, err_irq;
  logic [N-1:0] m_psel, m_pready = '0, m_pslverr = '0;
  logic [N-1:0][DW-1:0] m_prdata = '0;
  int errors = 0, checks = 0;
  bit mv = 0, mt = 0;
  logic [AW-1:0] ma = '0;
  int waits [6] = '{0, 1, 2, 3, 7, 20};

  apb_decode_mux #(.NumSlaves(N), .AddrWidth(AW), .DataWidth(DW), .SlvBase(BASE),
                   .SlvLast(LAST), .TimeoutCycles(T)) dut (
    .clk_i(clk), .rst_i(rst), .s_psel_i(s_psel), .s_penable_i(s_penable),
    .s_pwrite_i(s_pwrite), .s_paddr_i(s_paddr), .s_pwdata_i(s_pwdata),
    .s_prdata_o(s_prdata), .s_pready_o(s_pready), .s_pslverr_o(s_pslverr),
    .m_psel_o(m_psel), .m_penable_o(m_penable), .m_pwrite_o(m_pwrite),
    .m_paddr_o(m_paddr), .m_pwdata_o(m_pwdata), .m_prdata_i(m_prdata),
    .m_pready_i(m_pready), .m_pslverr_i(m_pslverr), .err_clr_i(err_clr),
    .err_valid_o(err_valid), .err_timeout_o(err_timeout), .err_addr_o(err_addr),
    .err_irq_o(err_irq));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_psel"}, m_psel, 0);
    chk({tag, "_pready"}, s_pready, 0);
    chk({tag, "_pslverr"}, s_pslverr, 0);
    chk({tag, "_prdata"}, s_prdata, 0);
    chk({tag, "_penable"}, m_penable, 0);
    chk({tag, "_err_valid"}, err_valid, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
    chk({tag, "_err_addr"}, err_addr, 0);
    chk({tag, "_irq"}, err_irq, 0);
  endtask

  // One full transfer: slave idx = rule hit, w = wait states before its pready.
  task automatic xfer(input logic [31:0] a, input bit wr, input logic [31:0] wd, input int w,
                      input bit serr, input logic [31:0] rd, input bit clr);
    int idx, last_k;
    bit berr;
    logic [N-1:0] oh;
    idx = (a >= 32'h1000 && a < 32'h5000) ? int'(a >> 12) - 1 : -1;
    last_k = idx < 0 ? 1 : (w < T ? w + 1 : T + 1);
    berr = idx < 0 || w >= T;
    oh = idx < 0 ? '0 : N'(1) << idx;
    @(posedge clk); #1;
    s_psel = 1; s_penable = 0; s_paddr = a; s_pwrite = wr; s_pwdata = wd; m_pready = '0;
    @(negedge clk);
    chk("setup_psel", m_psel, oh);
    chk("setup_pready", s_pready, 0);
    chk("paddr_bcast", m_paddr, a);
    chk("pwdata_bcast", m_pwdata, wd);
    chk("pwrite_bcast", m_pwrite, wr);
    for (int k = 1; k <= last_k; k++) begin
      @(posedge clk); #1;
      s_penable = 1;
      err_clr = clr && k == last_k;
      for (int j = 0; j < N; j++) begin
        m_prdata[j] = $urandom;
        m_pslverr[j] = 1'($urandom_range(0, 1));
        m_pready[j] = 1'($urandom_range(0, 1));
      end
      if (idx >= 0) begin
        m_pready[idx] = k == w + 1;
        m_pslverr[idx] = serr;
        m_prdata[idx] = rd;
      end
      @(negedge clk);
      chk("acc_psel", m_psel, (berr && k == last_k) ? '0 : oh);
      chk("acc_penable", m_penable, idx >= 0 && !(berr && k == last_k));
      chk("acc_pready", s_pready, k == last_k);
      chk("acc_irq", err_irq, 0);
      if (k == last_k) begin
        chk("resp_pslverr", s_pslverr, berr ? 1'b1 : serr);
        chk("resp_prdata", s_prdata, berr ? 32'h0 : rd);
      end
    end
    if (berr) begin
      mv = 1; mt = idx >= 0; ma = a;
    end else if (clr) mv = 0;
    @(posedge clk); #1;
    s_psel = 0; s_penable = 0; err_clr = 0; m_pready = '1;
    @(negedge clk);
    chk("irq", err_irq, berr);
    chk("err_valid", err_valid, mv);
    if (mv) begin
      chk("err_addr", err_addr, ma);
      chk("err_timeout", err_timeout, mt);
    end
    chk("late_pready", s_pready, 0);
    chk("idle_psel", m_psel, 0);
    m_pready = '0;
  endtask

  initial begin
    logic [31:0] a, bnd [6];
    bnd = '{32'h0FFF, 32'h1000, 32'h1FFF, 32'h2000, 32'h4FFF, 32'h5000};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1;
    rst = 0;
    xfer(32'h2004, 1, 32'hA5A5_0001, 0, 0, 0, 0);
    xfer(32'h8000, 0, 0, 0, 0, 0, 0);
    xfer(32'h3000, 0, 0, 20, 0, 0, 0);
    xfer(32'h4010, 0, 0, 7, 1, 32'h1234, 0);
    xfer(32'h9000, 0, 0, 0, 0, 0, 1);
    xfer(32'h1000, 1, 32'h55, 0, 0, 0, 1);
    foreach (bnd[i]) xfer(bnd[i], 0, $urandom, waits[$urandom_range(0, 3)], 0, $urandom, 0);
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: a = $urandom_range(0, 32'hFFF);
        1: a = 32'h5000 + $urandom_range(0, 32'hFFFF);
        default: a = 32'h1000 + $urandom_range(0, 32'h3FFF);
      endcase
      xfer(a, 1'($urandom_range(0, 1)), $urandom, waits[$urandom_range(0, 5)],
           1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3) == 0);
    end
    xfer(32'h7000, 0, 0, 0, 0, 0, 0);
    // Reset while slave3 stalls: counter holds 5 in access cycle 6.
    @(posedge clk); #1;
    s_psel = 1; s_penable = 0; s_paddr = 32'h4008; m_pready = '0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      s_penable = 1;
      rst = k == 6;
    end
    @(posedge clk); #1;
    rst = 0; s_psel = 0; s_penable = 0; s_paddr = '0; s_pwrite = 0; s_pwdata = '0;
    @(negedge clk);
    chk_quiet("midreset");
    mv = 0; mt = 0; ma = '0;
    xfer(32'h1010, 1, 32'hCAFE, 1, 0, 32'hBEEF, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
